// File: rtl/cp0_unit_pkg.sv
// Shared constants for the P7 coprocessor-0: exception codes, CP0 register numbers, field bits.
package cp0_unit_pkg;

  localparam logic [4:0] CodeNone = 5'd0;
  localparam logic [4:0] CodeInt  = 5'd0;

  localparam logic [4:0] Cp0Count   = 5'd9;
  localparam logic [4:0] Cp0Compare = 5'd11;
  localparam logic [4:0] Cp0Sr      = 5'd12;
  localparam logic [4:0] Cp0Cause   = 5'd13;
  localparam logic [4:0] Cp0Epc     = 5'd14;
  localparam logic [4:0] Cp0PrId    = 5'd15;

  localparam int unsigned SrIeBit  = 0;
  localparam int unsigned SrExlBit = 1;
  localparam int unsigned ImLo     = 10;
  localparam int unsigned ImHi     = 15;

  function automatic logic [31:0] sr_word(input logic [5:0] im, input logic exl, input logic ie);
    logic [31:0] w;
    w = '0;
    w[ImHi:ImLo] = im;
    w[SrExlBit]  = exl;
    w[SrIeBit]   = ie;
    return w;
  endfunction

  function automatic logic [31:0] cause_word(input logic bd, input logic [5:0] ip,
                                             input logic [4:0] exc);
    return {bd, 15'b0, ip, 3'b0, exc, 2'b0};
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer with a sticky pending flag; only instantiated when CP0_TIMER_EN is defined.
module cp0_timer (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        count_we_i,
  input  logic        compare_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        pending_o
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        pending_q, pending_d;

  always_comb begin
    count_d   = count_we_i ? wdata_i : count_q + 32'd1;
    compare_d = compare_we_i ? wdata_i : compare_q;
    // A Compare write acknowledges the interrupt; otherwise the flag is sticky.
    pending_d = compare_we_i ? 1'b0
                             : (pending_q | ((count_q == compare_q) && (compare_q != 32'd0)));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q   <= '0;
      compare_q <= '0;
      pending_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      pending_q <= pending_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign pending_o = pending_q;

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor-0 for the P7 pipeline: exception/interrupt request, SR/Cause/EPC, mfc0/mtc0.
// Optional Count/Compare timer enabled by defining CP0_TIMER_EN.
module cp0_unit
  import cp0_unit_pkg::*;
#(
  parameter logic [31:0] PRID       = 32'h2023_0007,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [4:0]  CP0Add,
  input  logic [31:0] CP0In,
  output logic [31:0] CP0Out,
  input  logic [31:0] VPC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic        Req,
  output logic [31:0] EPCOut,
  output logic [31:0] HandlerPC
);

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_q, exc_d;
  logic [31:0] epc_q, epc_d;

  logic        int_req, exc_req, req;
  logic        wr;
  logic        timer_pending;
  logic [5:0]  ip_eff;

  assign wr = en & ~req;

`ifdef CP0_TIMER_EN
  logic [31:0] count, compare;

  cp0_timer u_timer (
    .clk_i        (clk),
    .rst_ni       (reset),
    .count_we_i   (wr && (CP0Add == Cp0Count)),
    .compare_we_i (wr && (CP0Add == Cp0Compare)),
    .wdata_i      (CP0In),
    .count_o      (count),
    .compare_o    (compare),
    .pending_o    (timer_pending)
  );
`else
  assign timer_pending = 1'b0;
`endif

  assign ip_eff  = {HWInt[5] | timer_pending, HWInt[4:0]};
  assign int_req = ie_q & ~exl_q & (|(ip_eff & im_q));
  assign exc_req = ~exl_q & (ExcCodeIn != CodeNone);
  assign req     = int_req | exc_req;
  // Gate with reset so Req drops in the same cycle reset is pulled low.
  assign Req     = reset & req;

  always_comb begin
    im_d  = im_q;
    exl_d = exl_q;
    ie_d  = ie_q;
    bd_d  = bd_q;
    ip_d  = ip_eff;
    exc_d = exc_q;
    epc_d = epc_q;
    if (req) begin
      exl_d = 1'b1;
      bd_d  = BDIn;
      exc_d = int_req ? CodeInt : ExcCodeIn;
      epc_d = BDIn ? VPC - 32'd4 : VPC;
    end else begin
      if (EXLClr) exl_d = 1'b0;
      // The mtc0 assignment comes last so it overrides EXLClr on EXL.
      if (wr && (CP0Add == Cp0Sr)) begin
        im_d  = CP0In[ImHi:ImLo];
        exl_d = CP0In[SrExlBit];
        ie_d  = CP0In[SrIeBit];
      end
      if (wr && (CP0Add == Cp0Epc)) epc_d = CP0In;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im_q  <= '0;
      exl_q <= 1'b0;
      ie_q  <= 1'b0;
      bd_q  <= 1'b0;
      ip_q  <= '0;
      exc_q <= '0;
      epc_q <= '0;
    end else begin
      im_q  <= im_d;
      exl_q <= exl_d;
      ie_q  <= ie_d;
      bd_q  <= bd_d;
      ip_q  <= ip_d;
      exc_q <= exc_d;
      epc_q <= epc_d;
    end
  end

  always_comb begin
    CP0Out = '0;
    unique case (CP0Add)
      Cp0Sr:      CP0Out = sr_word(im_q, exl_q, ie_q);
      Cp0Cause:   CP0Out = cause_word(bd_q, ip_q, exc_q);
      Cp0Epc:     CP0Out = epc_q;
      Cp0PrId:    CP0Out = PRID;
`ifdef CP0_TIMER_EN
      Cp0Count:   CP0Out = count;
      Cp0Compare: CP0Out = compare;
`endif
      default:    CP0Out = '0;
    endcase
  end

  assign EPCOut    = epc_q;
  assign HandlerPC = HANDLER_PC;

endmodule

// File: doc/cp0_unit.md
Name: cp0_unit

Overview:
- Coprocessor-0 for the P7 pipeline. It receives the per-stage exception code, branch-delay flag and victim PC, plus external hardware interrupts.
- It decides the exception/interrupt request, latches SR/Cause/EPC, and returns EPC to decode for eret. It also serves mfc0/mtc0.
- Sits beside the memory stage. Req flushes the pipeline and redirects fetch to the handler.

Parameters:
- PRID, 32'h2023_0007, constant value read at CP0 register 15.
- HANDLER_PC, 32'h0000_4180, exported unchanged on HandlerPC for fetch redirection.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- en  input  1  mtc0 write enable, from the memory-stage instruction.
- CP0Add  input  5  CP0 register number for mfc0/mtc0.
- CP0In  input  32  mtc0 write data.
- CP0Out  output  32  mfc0 read data.
- VPC  input  32  PC of the memory-stage instruction (victim).
- BDIn  input  1  victim is in a branch delay slot.
- ExcCodeIn  input  5  victim exception code; code_None = 0 means none.
- HWInt  input  6  external interrupt lines, level-sensitive.
- EXLClr  input  1  eret is in the memory stage.
- Req  output  1  take exception/interrupt this cycle.
- EPCOut  output  32  current EPC register, to decode.
- HandlerPC  output  32  equals HANDLER_PC.

Behaviour:
- Register bits:
  - SR(12): IM[15:10], EXL[1], IE[0]; all other bits read 0.
  - Cause(13): BD[31], IP[15:10], ExcCode[6:2]; others read 0.
  - EPC(14): full 32 bits.
  - PRId(15): constant PRID.
- Reset (reset=0, asynchronous): SR, Cause and EPC go to 0. Req=0, EPCOut=0, CP0Out=0 for any address other than 15.
- IntReq = IE & ~EXL & |(HWInt & IM). Comb.
- ExcReq = ~EXL & (ExcCodeIn != 0). Comb.
- Req = IntReq | ExcReq. Comb, zero latency. Interrupt has priority over exception.
- IP[15:10] <= HWInt every cycle, regardless of Req or EXL.
- On posedge with Req=1:
  - EXL <= 1.
  - BD <= BDIn.
  - ExcCode <= IntReq ? 0 : ExcCodeIn.
  - EPC <= BDIn ? VPC-4 : VPC, 32-bit wrap-around (VPC=0 with BD gives 32'hFFFF_FFFC).
- On posedge with Req=0 and EXLClr=1: EXL <= 0.
- EXLClr and Req together cannot both act: EXLClr without Req clears EXL; Req always wins the EXL update.
- mtc0 (en=1, Req=0):
  - Address 12 writes IM, EXL and IE from CP0In.
  - Address 14 writes EPC.
  - Writes to 13, 15 and unlisted addresses are ignored.
- mtc0 with Req=1 in the same cycle is dropped; the victim is the writing instruction.
- mtc0 to SR together with EXLClr: mtc0 value wins for EXL.
- CP0Out: combinational read of the register state before the current edge. Unlisted addresses read 0.
- EPCOut is the registered EPC. A same-cycle mtc0 to EPC is visible the following cycle; decode stalls eret against mtc0 14.
- Reset asserted mid-handler clears EXL immediately. Req deasserts in the same cycle.

Optional Feature:
- Macro: CP0_TIMER_EN.
- With macro: Count(9) and Compare(11) are 32-bit registers.
  - Count increments every cycle and wraps at 32'hFFFF_FFFF to 0.
  - The timer pending bit sets when Count==Compare and Compare!=0.
  - Effective IP[15] = HWInt[5] | pending.
  - mtc0 to 11 loads Compare and clears pending; mtc0 to 9 loads Count.
  - Reset clears Count, Compare and pending.
- Without macro: addresses 9 and 11 read 0, writes to them are ignored, IP[15] = HWInt[5].

Decomposition:
- macros.v gains:
  - `code_None`=0, `code_Int`=0, alongside the existing exception codes.
  - CP0 register numbers `cp0_SR`=12, `cp0_Cause`=13, `cp0_EPC`=14, `cp0_PRId`=15, `cp0_Count`=9, `cp0_Compare`=11.
  - SR/Cause field bit positions.
- One sub-module, cp0_timer (Count/Compare/pending). It is instantiated only under CP0_TIMER_EN.

Test Plan:
- Reset, then mfc0 at 15 gives CP0Out=32'h2023_0007. Read 12 gives 0. Req=0, EPCOut=0.
- ExcCodeIn=10 (RI), VPC=32'h3010, BDIn=0 gives Req=1 that cycle. Next cycle: EPC=32'h3010, ExcCode=10, EXL=1. A second ExcCodeIn=4 now gives Req=0.
- Exception with BDIn=1, VPC=32'h3008 gives EPC=32'h3004, Cause[31]=1. EXLClr pulse gives EXL=0 next cycle.
- mtc0 12 with 32'h0000_FC01, then HWInt=6'b000100 gives Req=1, ExcCode=0, Cause[12]=1. The same stimulus with IE=0 gives Req=0 while IP still shows 1.
- en=1, CP0Add=12 together with ExcCodeIn=5: the write is dropped, SR is unchanged except EXL=1. Pulling reset low mid-handler zeroes SR/Cause/EPC within the same cycle.
- CP0_TIMER_EN: IM[15]=1, IE=1, Compare=20, Count=0 gives Req=1 within 21 cycles with ExcCode=0. mtc0 11 clears pending.
